cp0_ctrl: RTL and testbench

CP0_CTRL -- requirements
Module: cp0_ctrl

---
 rtl/cp0_ctrl.sv | 87 ++++++++
 tb/tb_cp0_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_ctrl.sv
// rtl/cp0_ctrl.sv - Coprocessor 0: SR/Cause/EPC/PRId, exception and interrupt entry
module cp0_ctrl #(
    parameter logic [31:0] PRID = 32'h4C5A_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] Din,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] Dout
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc_q;

    logic        int_pend;
    logic        exc_pend;
    logic [31:0] pc_aligned;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign int_pend   = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_pend   = (ExcCode != 5'd0) & ~sr_exl;
    assign IntReq     = (int_pend | exc_pend) & ~reset;
    assign pc_aligned = {PC[31:2], 2'b00};
    assign EPC        = epc_q;

    assign sr_val    = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
    assign cause_val = {cause_bd, 15'h0, cause_ip, 3'h0, cause_exc, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= 6'h0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'h0;
            cause_exc <= 5'h0;
            epc_q     <= 32'h0;
        end else begin
            cause_ip <= HWInt;
            if (IntReq) begin
                // Exception entry; any concurrent mtc0 is dropped
                sr_exl    <= 1'b1;
                cause_exc <= int_pend ? 5'd0 : ExcCode;
                cause_bd  <= BD;
                epc_q     <= BD ? pc_aligned - 32'd4 : pc_aligned;
            end else begin
                if (WE && A2 == 5'd12) begin
                    sr_im  <= Din[15:10];
                    sr_ie  <= Din[0];
                    sr_exl <= Din[1] & ~EXLClr;
                end else if (EXLClr) begin
                    sr_exl <= 1'b0;
                end
                if (WE && A2 == 5'd14) begin
                    epc_q <= {Din[31:2], 2'b00};
                end
            end
        end
    end

    always_comb begin
        Dout = 32'h0;
        case (A1)
            5'd12:   Dout = sr_val;
            5'd13:   Dout = cause_val;
            5'd14:   Dout = epc_q;
            5'd15:   Dout = PRID;
            default: Dout = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb/tb_cp0_ctrl.sv - directed self-checking bench for cp0_ctrl
module tb_cp0_ctrl;

    localparam logic [31:0] PRID_V = 32'h4C5A_0001;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] Din;
    logic        WE;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] Dout;

    int checks = 0;
    int errors = 0;

    cp0_ctrl #(.PRID(PRID_V)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .WE(WE),
        .PC(PC), .BD(BD), .ExcCode(ExcCode), .HWInt(HWInt), .EXLClr(EXLClr),
        .IntReq(IntReq), .EPC(EPC), .Dout(Dout)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        A1 = a;
        #1;
        check(tag, Dout, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        #1;
        check(tag, {31'h0, IntReq}, {31'h0, exp});
    endtask

    task automatic idle();
        WE = 1'b0; A2 = 5'd0; Din = 32'h0; PC = 32'h0; BD = 1'b0;
        ExcCode = 5'd0; HWInt = 6'h0; EXLClr = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        WE = 1'b1; A2 = a; Din = d;
        tick();
        WE = 1'b0; A2 = 5'd0; Din = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        A1 = 5'd0;
        reset = 1'b1;
        tick();
        tick();
        chk_reg("rst_sr", 5'd12, 32'h0);
        chk_reg("rst_cause", 5'd13, 32'h0);
        chk_reg("rst_epc", 5'd14, 32'h0);
        chk_reg("rst_prid", 5'd15, PRID_V);
        chk_reg("unmapped", 5'd3, 32'h0);
        chk_irq("rst_irq", 1'b0);
        reset = 1'b0;

        // exception entry
        mtc0(5'd12, 32'h0000_FC01);
        chk_reg("sr_write", 5'd12, 32'h0000_FC01);
        ExcCode = 5'd12; PC = 32'h0000_3010; BD = 1'b0;
        chk_irq("exc_irq", 1'b1);
        tick();
        idle();
        chk_irq("exc_masked", 1'b0);
        chk_reg("exc_cause", 5'd13, 32'h0000_0030);
        chk_reg("exc_epc", 5'd14, 32'h0000_3010);
        check("exc_epc_port", EPC, 32'h0000_3010);
        chk_reg("exc_sr", 5'd12, 32'h0000_FC03);

        // eret with an interrupt waiting behind EXL
        HWInt = 6'b000010;
        chk_irq("exl_masks_int", 1'b0);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        chk_reg("eret_sr", 5'd12, 32'h0000_FC01);
        chk_irq("eret_int", 1'b1);
        PC = 32'h0000_3020;
        tick();
        idle();
        chk_reg("int_cause", 5'd13, 32'h0000_0800);
        chk_reg("int_epc", 5'd14, 32'h0000_3020);
        do_reset();

        // interrupt beats exception, branch delay slot
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'b000001; ExcCode = 5'd4; BD = 1'b1; PC = 32'h0000_3008;
        chk_irq("prio_irq", 1'b1);
        tick();
        idle();
        chk_reg("prio_cause", 5'd13, 32'h8000_0400);
        chk_reg("prio_epc", 5'd14, 32'h0000_3004);
        do_reset();

        // EPC wraparound with unaligned PC
        ExcCode = 5'd1; PC = 32'h0000_0003; BD = 1'b1;
        chk_irq("wrap_irq", 1'b1);
        tick();
        idle();
        chk_reg("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        chk_reg("wrap_cause", 5'd13, 32'h8000_0004);
        do_reset();

        // masking by IM and by IE
        mtc0(5'd12, 32'h0000_0001);
        HWInt = 6'h3F;
        chk_irq("im_mask", 1'b0);
        tick();
        chk_reg("ip_sample", 5'd13, 32'h0000_FC00);
        mtc0(5'd12, 32'h0000_FC00);
        chk_irq("ie_mask", 1'b0);
        chk_reg("ie_sr", 5'd12, 32'h0000_FC00);
        idle();
        do_reset();

        // mtc0 collides with exception entry
        ExcCode = 5'd10; PC = 32'h0000_3000;
        WE = 1'b1; A2 = 5'd14; Din = 32'h1234_5677;
        chk_irq("coll_irq", 1'b1);
        tick();
        idle();
        chk_reg("coll_epc", 5'd14, 32'h0000_3000);
        chk_reg("coll_cause", 5'd13, 32'h0000_0028);
        chk_reg("coll_sr", 5'd12, 32'h0000_0002);
        mtc0(5'd14, 32'h1234_5677);
        chk_reg("mtc0_epc", 5'd14, 32'h1234_5674);
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk_reg("ro_cause", 5'd13, 32'h0000_0028);
        mtc0(5'd15, 32'hFFFF_FFFF);
        chk_reg("ro_prid", 5'd15, PRID_V);

        // eret concurrent with SR write: EXL cleared, IM/IE from Din
        EXLClr = 1'b1;
        mtc0(5'd12, 32'h0000_FC03);
        EXLClr = 1'b0;
        chk_reg("eret_wr_sr", 5'd12, 32'h0000_FC01);

        // reset in the middle of a handler
        mtc0(5'd12, 32'h0);
        ExcCode = 5'd7; PC = 32'h0000_0100;
        tick();
        idle();
        chk_reg("mid_epc", 5'd14, 32'h0000_0100);
        reset = 1'b1; ExcCode = 5'd5;
        chk_irq("rst_exl_irq", 1'b0);
        tick();
        chk_irq("rst_gate_irq", 1'b0);
        chk_reg("mid_sr", 5'd12, 32'h0);
        chk_reg("mid_cause", 5'd13, 32'h0);
        chk_reg("mid_epc0", 5'd14, 32'h0);
        reset = 1'b0;
        chk_irq("post_rst_exc", 1'b1);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
